// File: rtl/apb_arb_pkg.sv
// Shared definitions for the multi-master APB arbiter: state encoding,
// default bus widths and the slave-select decode.
package apb_arb_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b001;
  localparam logic [2:0] ST_SETUP  = 3'b010;
  localparam logic [2:0] ST_ACCESS = 3'b100;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  // Address MSB picks the slave; result is {psel2, psel1}
  function automatic logic [1:0] slave_sel(input logic addr_msb);
    return addr_msb ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: the first set request searching upward
// from last_gnt+1, wrapping modulo NUM_REQ.
module apb_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_valid
);

  // Walk the requesters in rotated priority order and keep the first hit
  always_comb begin
    logic [IDX_W-1:0] sel;
    win_onehot = '0;
    win_idx    = '0;
    any_valid  = 1'b0;
    sel        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
      if (!any_valid && req_vec[sel]) begin
        any_valid       = 1'b1;
        win_onehot[sel] = 1'b1;
        win_idx         = sel;
      end
    end
  end

endmodule

// File: rtl/apb_multi_master_arbiter.sv
// APB master shared between NUM_REQ requesters: round-robin grant, one
// SETUP cycle, ACCESS with wait states and an optional timeout abort.
// Every output comes straight from a flop.
module apb_multi_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      busy,
  output logic                      PSEL1,
  output logic                      PSEL2,
  output logic                      PENABLE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]         state_q,    state_d;
  logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [NUM_REQ-1:0] gnt_q,      gnt_d;
  logic [NUM_REQ-1:0] done_q,     done_d;
  logic [DATA_W-1:0]  rdata_q,    rdata_d;
  logic               err_q,      err_d;
  logic               busy_q,     busy_d;
  logic               psel1_q,    psel1_d;
  logic               psel2_q,    psel2_d;
  logic               penable_q,  penable_d;
  logic [ADDR_W-1:0]  paddr_q,    paddr_d;
  logic               pwrite_q,   pwrite_d;
  logic [DATA_W-1:0]  pwdata_q,   pwdata_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  pick_addr;
  logic [DATA_W-1:0]  pick_wdata;
  logic               pick_write;

  // A requester still holding req in its done cycle must not be re-granted
  assign eligible = req & ~done_q;

  apb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_vec    (eligible),
    .last_gnt   (last_gnt_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any_valid  (pick_any)
  );

  // Select the winner's address, data and direction from the packed buses
  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    pick_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_addr  = req_addr[i*ADDR_W +: ADDR_W];
        pick_wdata = req_wdata[i*DATA_W +: DATA_W];
        pick_write = req_write[i];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequence
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = '0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    psel1_d    = psel1_q;
    psel2_d    = psel2_q;
    penable_d  = penable_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d            = ST_SETUP;
          gnt_d              = pick_onehot;
          last_gnt_d         = pick_idx;
          paddr_d            = pick_addr;
          pwdata_d           = pick_wdata;
          pwrite_d           = pick_write;
          {psel2_d, psel1_d} = slave_sel(pick_addr[ADDR_W-1]);
          penable_d          = 1'b0;
          busy_d             = 1'b1;
          cnt_d              = '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY || (TIMEOUT != 0 && cnt_q == CNT_LAST)) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          done_d    = gnt_q;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          cnt_d     = '0;
          if (PREADY) begin
            rdata_d = pwrite_q ? '0 : PRDATA;
            err_d   = PSLVERR;
          end else begin
            err_d   = 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer silently
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= IDX_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      psel1_q    <= 1'b0;
      psel2_q    <= 1'b0;
      penable_q  <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      psel1_q    <= psel1_d;
      psel2_q    <= psel2_d;
      penable_q  <= penable_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign PSEL1   = psel1_q;
  assign PSEL2   = psel2_q;
  assign PENABLE = penable_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: doc/apb_multi_master_arbiter.md
Name: apb_multi_master_arbiter

Overview:
Shares the single APB bus (two slaves, selected by PADDR[8]) between NUM_REQ independent requesters, and acts as the APB master for the granted requester.
- Arbitrates round-robin, runs the SETUP/ACCESS sequence and honours PREADY wait states.
- Bounds each transfer with a timeout, then returns read data and error status to the granted requester.
- Sits between the requester blocks and the slave-side PREADY/PRDATA/PSLVERR muxes.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 9, APB address width; bit ADDR_W-1 selects the slave
DATA_W, 8, APB data width
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESETn  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester transfer request; held high until done
req_write  in  NUM_REQ  per-requester direction: 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
gnt  out  NUM_REQ  one-hot; high for the granted requester during SETUP and ACCESS
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  out  DATA_W  read data; valid while any done bit is high
err  out  1  error flag; valid while any done bit is high
busy  out  1  high in SETUP and ACCESS
PSEL1  out  1  select for slave 1 (PADDR[ADDR_W-1]=0)
PSEL2  out  1  select for slave 2 (PADDR[ADDR_W-1]=1)
PENABLE  out  1  APB enable
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  muxed slave read data
PREADY  in  1  muxed slave ready
PSLVERR  in  1  muxed slave error

Behaviour:
- Reset: when PRESETn is low at a clock edge, all outputs are driven to 0 from the next cycle.
  - State goes to IDLE, the timeout counter clears, and the round-robin pointer last_gnt is set to NUM_REQ-1, so requester 0 has top priority first.
  - A reset during SETUP or ACCESS aborts the transfer with no done pulse.
- Registers: all outputs are registered. No combinational path from req or APB inputs to any output.
- State machine: three states, IDLE, SETUP and ACCESS.
- IDLE:
  - Eligible requests are req with the bit of the requester currently pulsing done masked out, so a requester still holding req in its done cycle is not re-granted.
  - If any request is eligible, pick the winner: the first set bit searching last_gnt+1 upward, wrapping modulo NUM_REQ.
  - Latch the winner's address, write data and direction into PADDR/PWDATA/PWRITE, set gnt, update last_gnt, and go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL1 or PSEL2 is high, chosen by PADDR[ADDR_W-1]; PENABLE=0; busy=1.
  - Always go to ACCESS.
- ACCESS:
  - PSEL held, PENABLE=1; PADDR, PWDATA and PWRITE are stable from SETUP.
  - PREADY=1: return to IDLE, drop PSEL/PENABLE/gnt, and pulse done[winner] in the next cycle.
    - rdata = PRDATA for a read, 0 for a write.
    - err = PSLVERR.
  - PREADY=0: increment the wait counter.
    - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 while PREADY is still 0, abort: return to IDLE with done[winner]=1, err=1, rdata=0.
- Latency: from req seen in IDLE to the done pulse is 3 cycles with zero wait states, plus 1 cycle per wait state. At least one IDLE cycle separates transfers.
- Arbitration in the done cycle is legal; the next SETUP can start the following cycle.
- Ignored inputs:
  - Changes to req, req_addr or req_wdata after grant have no effect until the next arbitration.
  - A req dropped mid-transfer does not cancel the transfer.
- Outside transfers: PSEL1 and PSEL2 are never both high. PENABLE is never high without a PSEL. PSLVERR and PRDATA are ignored except in the ACCESS cycle where PREADY=1.
- Idle bus: PADDR/PWDATA/PWRITE hold their last values; done, err and rdata return to 0 the cycle after their pulse.

Decomposition:
- Package apb_arb_pkg holds:
  - the state encoding localparams ST_IDLE=3'b001, ST_SETUP=3'b010, ST_ACCESS=3'b100;
  - default widths APB_ADDR_W=9 and APB_DATA_W=8;
  - a function for slave-select decode from the address MSB.
- One sub-module, apb_rr_picker: combinational round-robin picker.
  - Inputs: masked req vector and last_gnt.
  - Outputs: one-hot winner, its encoded index, and an any_valid flag.

Test Plan:
- Single write, zero wait: req0=1, addr 9'h012, wdata 8'hA5, PREADY=1 -> SETUP with PSEL1=1, then ACCESS with PENABLE=1, then done[0] 3 cycles after req, err=0.
- Simultaneous requests: req=2'b11 both held after reset -> grant order 0,1,0,1 across four transfers; no done pulse is ever followed by an immediate re-grant to the same requester while the other requests.
- Wait states: read to 9'h105, PREADY low for 3 ACCESS cycles, PRDATA=8'h3C -> PSEL2=1 throughout, done at cycle 6, rdata=8'h3C.
- Slave error: write with PSLVERR=1 and PREADY=1 -> done pulse with err=1; next transfer has err=0.
- Timeout: TIMEOUT=4, PREADY stuck low -> abort after 4 ACCESS cycles; done with err=1, rdata=0; bus idle next cycle.
- Reset mid-ACCESS: PRESETn low during ACCESS -> next cycle all outputs 0, no done; after release, req1 with req0 also pending is granted requester 0 first.
